// File: rtl/modexp_stream_seq.sv
`default_nettype none
// ============================================================================
// Module  : modexp_stream_seq
// Brief   : Streams 4096-bit operands into a ModExp core and streams its result back out.
// Revision: 1.0 - initial release
// ============================================================================
module modexp_stream_seq #(
  parameter int DATA_WIDTH    = 64,
  parameter int NUM_WORDS     = 64,
  parameter int COMPLETE_CODE = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_m,
  input  logic [DATA_WIDTH-1:0] in_e,
  input  logic [DATA_WIDTH-1:0] in_n,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_t,
  input  logic [63:0]           in_nprime0,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] me_m_buf,
  output logic [DATA_WIDTH-1:0] me_e_buf,
  output logic [DATA_WIDTH-1:0] me_n_buf,
  output logic [DATA_WIDTH-1:0] me_r_buf,
  output logic [DATA_WIDTH-1:0] me_t_buf,
  output logic [63:0]           me_nprime0,
  output logic                  me_start_input,
  output logic                  me_start_compute,
  output logic                  me_get_result,
  input  logic [4:0]            me_exp_state,
  input  logic [DATA_WIDTH-1:0] me_res_out
);

  localparam int           c_IW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [6:0]   c_LAST     = 7'(NUM_WORDS - 1);
  localparam logic [4:0]   c_COMPLETE = 5'(COMPLETE_CODE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_SKIP    = 3'd3,
    S_CAPTURE = 3'd4,
    S_EMIT    = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_in_ready;
  logic [6:0]            r_cnt;
  logic [6:0]            r_rd;
  logic                  r_out_valid;
  logic                  r_error;
  logic [DATA_WIDTH-1:0] r_m;
  logic [DATA_WIDTH-1:0] r_e;
  logic [DATA_WIDTH-1:0] r_n;
  logic [DATA_WIDTH-1:0] r_r;
  logic [DATA_WIDTH-1:0] r_t;
  logic [63:0]           r_nprime0;
  logic                  r_start_input;
  logic                  r_start_compute;
  logic                  r_get_result;
  logic [DATA_WIDTH-1:0] r_res [NUM_WORDS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_in_ready      <= 1'b1;
      r_cnt           <= '0;
      r_rd            <= '0;
      r_out_valid     <= 1'b0;
      r_error         <= 1'b0;
      r_m             <= '0;
      r_e             <= '0;
      r_n             <= '0;
      r_r             <= '0;
      r_t             <= '0;
      r_nprime0       <= '0;
      r_start_input   <= 1'b0;
      r_start_compute <= 1'b0;
      r_get_result    <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_m           <= in_m;
            r_e           <= in_e;
            r_n           <= in_n;
            r_r           <= in_r;
            r_t           <= in_t;
            r_nprime0     <= in_nprime0;
            r_start_input <= 1'b1;
            r_cnt         <= 7'd1;
            r_in_ready    <= (c_LAST != 7'd0);
            r_state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          // in_ready low inside LOAD marks the cycle the last word sits on the buffers
          if (r_in_ready) begin
            if (in_valid) begin
              r_m   <= in_m;
              r_e   <= in_e;
              r_n   <= in_n;
              r_r   <= in_r;
              r_t   <= in_t;
              r_cnt <= r_cnt + 7'd1;
              if (r_cnt == c_LAST) begin
                r_in_ready <= 1'b0;
              end
            end else begin
              r_error       <= 1'b1;
              r_start_input <= 1'b0;
              r_m           <= '0;
              r_e           <= '0;
              r_n           <= '0;
              r_r           <= '0;
              r_t           <= '0;
              r_cnt         <= '0;
              r_state       <= S_IDLE;
            end
          end else begin
            r_start_compute <= 1'b1;
            r_get_result    <= 1'b1;
            r_m             <= '0;
            r_e             <= '0;
            r_n             <= '0;
            r_r             <= '0;
            r_t             <= '0;
            r_cnt           <= '0;
            r_state         <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          if (me_exp_state == c_COMPLETE) begin
            r_state <= S_SKIP;
          end
        end
        S_SKIP: begin
          r_cnt   <= '0;
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (r_cnt == c_LAST) begin
            r_cnt       <= '0;
            r_rd        <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT;
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (r_rd == c_LAST) begin
              r_out_valid     <= 1'b0;
              r_start_input   <= 1'b0;
              r_start_compute <= 1'b0;
              r_get_result    <= 1'b0;
              r_rd            <= '0;
              r_in_ready      <= 1'b1;
              r_state         <= S_IDLE;
            end else begin
              r_rd <= r_rd + 7'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Result storage needs no reset: it is only read after a full capture pass.
  always_ff @(posedge clk) begin
    if (r_state == S_CAPTURE) begin
      r_res[r_cnt[c_IW-1:0]] <= me_res_out;
    end
  end

  assign in_ready         = r_in_ready;
  assign out_valid        = r_out_valid;
  assign out_data         = r_out_valid ? r_res[r_rd[c_IW-1:0]] : '0;
  assign out_last         = r_out_valid && (r_rd == c_LAST);
  assign busy             = (r_state != S_IDLE);
  assign error            = r_error;
  assign me_m_buf         = r_m;
  assign me_e_buf         = r_e;
  assign me_n_buf         = r_n;
  assign me_r_buf         = r_r;
  assign me_t_buf         = r_t;
  assign me_nprime0       = r_nprime0;
  assign me_start_input   = r_start_input;
  assign me_start_compute = r_start_compute;
  assign me_get_result    = r_get_result;

endmodule
`default_nettype wire

// File: tb/tb_modexp_stream_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_modexp_stream_seq
// Brief   : Self-checking bench for modexp_stream_seq with a stub ModExp core.
// Revision: 1.0 - initial release
// ============================================================================
module tb_modexp_stream_seq;

  localparam int NW = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_m, in_e, in_n, in_r, in_t, in_nprime0;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;
  logic        error;
  logic [63:0] me_m_buf, me_e_buf, me_n_buf, me_r_buf, me_t_buf, me_nprime0;
  logic        me_start_input, me_start_compute, me_get_result;
  logic [4:0]  me_exp_state;
  logic [63:0] me_res_out;

  int          checks = 0;
  int          errors = 0;
  int unsigned stub_cnt = 0;
  int unsigned stub_delay = 10;
  logic        force_cmp = 1'b0;

  modexp_stream_seq dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_m(in_m), .in_e(in_e), .in_n(in_n), .in_r(in_r), .in_t(in_t),
    .in_nprime0(in_nprime0),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .error(error),
    .me_m_buf(me_m_buf), .me_e_buf(me_e_buf), .me_n_buf(me_n_buf),
    .me_r_buf(me_r_buf), .me_t_buf(me_t_buf), .me_nprime0(me_nprime0),
    .me_start_input(me_start_input), .me_start_compute(me_start_compute),
    .me_get_result(me_get_result), .me_exp_state(me_exp_state),
    .me_res_out(me_res_out)
  );

  always #5 clk = ~clk;

  // Stub core: counts cycles since start_compute, completes after stub_delay cycles.
  always @(posedge clk) begin
    if (!me_start_compute) stub_cnt <= 0;
    else                   stub_cnt <= stub_cnt + 1;
  end
  assign me_exp_state = (force_cmp || (me_start_compute && stub_cnt >= stub_delay)) ? 5'd9 : 5'd0;
  assign me_res_out   = 64'h100 + 64'(stub_cnt);

  typedef struct {
    logic [63:0] m_base;
    int unsigned delay;
    bit          stall;
    bit          force_cmp;
    logic [63:0] exp_first;
  } txn_t;

  txn_t tbl [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wd(input logic [63:0] b, input int i, input int k);
    return b + 64'(i) + 64'(k) * 64'h100;
  endfunction

  task automatic drive_beat(input logic [63:0] b, input int i);
    in_m       = wd(b, i, 0);
    in_e       = wd(b, i, 1);
    in_n       = wd(b, i, 2);
    in_r       = wd(b, i, 3);
    in_t       = wd(b, i, 4);
    in_nprime0 = b ^ 64'hC0FFEE ^ 64'(i);
    in_valid   = 1'b1;
  endtask

  task automatic load_beats(input logic [63:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      drive_beat(b, i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_start_input", 64'(me_start_input), 64'd0);
    check("rst_start_compute", 64'(me_start_compute), 64'd0);
    check("rst_get_result", 64'(me_get_result), 64'd0);
    check("rst_m_buf", me_m_buf, 64'd0);
    check("rst_nprime0", me_nprime0, 64'd0);
  endtask

  task automatic run_txn(input txn_t t);
    int          idx;
    int          guard;
    logic [63:0] prev;
    logic        stalled;
    stub_delay = t.delay;
    check("idle_in_ready", 64'(in_ready), 64'd1);
    force_cmp = t.force_cmp;
    for (int i = 0; i < NW; i++) begin
      check("load_in_ready", 64'(in_ready), 64'd1);
      drive_beat(t.m_base, i);
      step();
      check("load_m", me_m_buf, wd(t.m_base, i, 0));
      check("load_e", me_e_buf, wd(t.m_base, i, 1));
      check("load_n", me_n_buf, wd(t.m_base, i, 2));
      check("load_r", me_r_buf, wd(t.m_base, i, 3));
      check("load_t", me_t_buf, wd(t.m_base, i, 4));
      check("load_start_input", 64'(me_start_input), 64'd1);
      check("load_no_compute", 64'(me_start_compute), 64'd0);
    end
    check("load_nprime0", me_nprime0, t.m_base ^ 64'hC0FFEE);
    check("last_beat_in_ready", 64'(in_ready), 64'd0);
    in_valid  = 1'b0;
    force_cmp = 1'b0;
    step();
    check("compute_start", 64'(me_start_compute), 64'd1);
    check("compute_get_result", 64'(me_get_result), 64'd1);
    check("compute_start_input", 64'(me_start_input), 64'd1);
    check("compute_buf_zero", me_m_buf, 64'd0);
    check("compute_in_ready", 64'(in_ready), 64'd0);
    check("compute_busy", 64'(busy), 64'd1);
    guard = 0;
    while (!out_valid && guard < 400) begin
      step();
      guard++;
    end
    check("emit_latency", 64'(guard), 64'(t.delay + 66));
    idx = 0;
    stalled = 1'b0;
    prev = '0;
    guard = 0;
    while (idx < NW && guard < 2000) begin
      if (!out_valid) break;
      check("emit_data", out_data, t.exp_first + 64'(idx));
      check("emit_last", 64'(out_last), 64'(idx == NW - 1));
      if (stalled) check("emit_hold", out_data, prev);
      out_ready = t.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      prev = out_data;
      stalled = !out_ready;
      step();
      guard++;
      if (out_ready) idx++;
    end
    out_ready = 1'b0;
    check("words_delivered", 64'(idx), 64'(NW));
    check("done_out_valid", 64'(out_valid), 64'd0);
    check("done_busy", 64'(busy), 64'd0);
    check("done_in_ready", 64'(in_ready), 64'd1);
    check("done_start_input", 64'(me_start_input), 64'd0);
    check("done_start_compute", 64'(me_start_compute), 64'd0);
    check("done_get_result", 64'(me_get_result), 64'd0);
  endtask

  initial begin
    int g;
    tbl[0] = '{m_base: 64'h0000_0000_0000_1000, delay: 10, stall: 1'b0, force_cmp: 1'b0, exp_first: 64'h10C};
    tbl[1] = '{m_base: 64'hA5A5_0000_0000_0000, delay: 0,  stall: 1'b1, force_cmp: 1'b0, exp_first: 64'h102};
    tbl[2] = '{m_base: 64'hFFFF_FFFF_FFFF_FFC0, delay: 3,  stall: 1'b1, force_cmp: 1'b1, exp_first: 64'h105};
    tbl[3] = '{m_base: 64'h0000_0000_0000_0000, delay: 25, stall: 1'b0, force_cmp: 1'b1, exp_first: 64'h11B};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_m = '0; in_e = '0; in_n = '0; in_r = '0; in_t = '0; in_nprime0 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) run_txn(tbl[i]);

    // Load abort after beat 20
    stub_delay = 10;
    load_beats(64'h5555_0000, 21);
    check("abort_pre_error", 64'(error), 64'd0);
    step();
    check("abort_error", 64'(error), 64'd1);
    check("abort_start_input", 64'(me_start_input), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_buf_zero", me_m_buf, 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    step();
    check("abort_error_once", 64'(error), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("abort_no_out_valid", 64'(out_valid), 64'd0);
    end

    // Reset during capture index 30
    stub_delay = 5;
    load_beats(64'h7777_0000, NW);
    step();
    g = 0;
    while (stub_cnt != 5 + 2 + 30 && g < 300) begin
      step();
      g++;
    end
    check("capture_reached", 64'(stub_cnt), 64'd37);
    check("capture_busy", 64'(busy), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_state();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_out_valid", 64'(out_valid), 64'd0);
      check("post_rst_error", 64'(error), 64'd0);
    end
    run_txn(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
